sparse: RTL and testbench
=========================

SPARSE -- requirements
Module: sparse

Interface
REQ-001 Parameters: none; sizes are fixed constants (see Structure).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 Vector_A  input  128  16 unsigned 8-bit elements; element i = bits [8*i+7 : 8*i].
REQ-005 Vector_B  input  128  same packing as Vector_A.
REQ-006 out_Final  output  25  registered unsigned dot product of the last captured vector pair.

Function
REQ-007 Result SHALL be sum over i=0..15 of A[i]*B[i]: unsigned 8x8 products, each 16 bits, zero-extended and accumulated modulo 2^25; maximum 1,040,400 never wraps.
REQ-008 States SHALL be IDLE, LOAD, SCAN and DONE.
REQ-009 IDLE SHALL go to LOAD on the next edge.
REQ-010 LOAD edge SHALL capture Vector_A/Vector_B into internal registers, clear the accumulator, set pending mask bit i when A[i]!=0 and B[i]!=0, then enter SCAN.
REQ-011 Each SCAN edge with a non-empty mask SHALL add the product of the lowest-indexed pending element to the accumulator and clear that bit; one product per cycle.
REQ-012 A SCAN edge with an empty mask (including empty at entry) SHALL load out_Final from the accumulator and enter DONE.
REQ-013 Latency: with K pending pairs, out_Final updates on edge K+2 counted from the LOAD edge (=1).
REQ-014 out_Final SHALL hold its previous value until the commit in REQ-012; no partial sums visible.
REQ-015 In DONE, each edge SHALL compare inputs against captured copies; any differing bit (unknown-valued bits in simulation count as differing) moves to LOAD, otherwise DONE holds.
REQ-016 Input changes during LOAD->SCAN are ignored until DONE is reached.

Reset
REQ-017 rst low at an edge SHALL force IDLE, out_Final=0, accumulator=0, mask=0 and captured vectors=0, overriding all other activity, including mid-SCAN.
REQ-018 First LOAD SHALL occur on the second edge after rst returns high.

Configuration
REQ-019 Macro SPARSE_SKIP_EN defined: mask as in REQ-010, zero pairs skipped, K = number of nonzero pairs.
REQ-020 SPARSE_SKIP_EN undefined: all 16 mask bits set at LOAD, K = 16 always, identical out_Final values.

Structure
REQ-021 Package sparse_pkg SHALL hold N_ELEM=16, ELEM_W=8, PROD_W=16, ACC_W=25 and the state encoding.
REQ-022 One sub-module sparse_pick: 16-bit lowest-set-bit priority encoder giving 4-bit index and valid flag.
REQ-023 Single multiplier and single 25-bit adder shared across all elements.

Verification
REQ-024 All bytes 0xFF on both inputs -> out_Final = 1,040,400 (0x0FE010), 18 edges after LOAD with skip (same without).
REQ-025 Vector_A = 0, Vector_B = all 0xFF -> out_Final = 0, 2 edges after LOAD with skip, 18 without.
REQ-026 A[0]=3, B[0]=5, all else 0 -> out_Final = 15, 3 edges after LOAD with skip.
REQ-027 A all bytes 0x01, B[i]=i -> out_Final = 120; with skip K=15 (latency 17), without 18.
REQ-028 Result 15 held in DONE, then inputs changed to all 0xFF -> LOAD next edge, out_Final stays 15 until committing 1,040,400.
REQ-029 rst low during SCAN -> out_Final = 0 next edge; after release, full recompute gives correct result.

Source files
------------

// File: rtl/sparse_pkg.sv
// Shared sizes and FSM encoding for the sparse dot-product engine.
package sparse_pkg;
  localparam int N_ELEM = 16;
  localparam int ELEM_W = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 25;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/sparse_pick.sv
// Lowest-set-bit priority encoder over the pending-element mask.
module sparse_pick
  import sparse_pkg::*;
(
  input  logic [N_ELEM-1:0] req,
  output logic [IDX_W-1:0]  idx,
  output logic              vld
);
  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = N_ELEM - 1; i >= 0; i--)
      if (req[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/sparse.sv
// Sequential 16-element unsigned dot product with one shared multiplier/adder.
// Define SPARSE_SKIP_EN to skip element pairs where either operand is zero.
module sparse
  import sparse_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_ELEM*ELEM_W-1:0] Vector_A,
  input  logic [N_ELEM*ELEM_W-1:0] Vector_B,
  output logic [ACC_W-1:0]         out_Final
);
  state_t state, nxt;

  logic [N_ELEM-1:0][ELEM_W-1:0] vec_a, vec_b, cap_a, cap_b;
  logic [N_ELEM-1:0]             mask, load_mask;
  logic [ACC_W-1:0]              acc, acc_sum;
  logic [PROD_W-1:0]             prod;
  logic [IDX_W-1:0]              pick_idx;
  logic                          pick_vld;

  assign vec_a = Vector_A;
  assign vec_b = Vector_B;

  always_comb begin
    load_mask = '0;
`ifdef SPARSE_SKIP_EN
    for (int i = 0; i < N_ELEM; i++)
      load_mask[i] = (|vec_a[i]) && (|vec_b[i]);
`else
    load_mask = '1;
`endif
  end

  sparse_pick u_pick (
    .req (mask),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign prod    = PROD_W'(cap_a[pick_idx]) * PROD_W'(cap_b[pick_idx]);
  assign acc_sum = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = LOAD;
      LOAD: nxt = SCAN;
      SCAN: if (!pick_vld) nxt = DONE;
      // Equality-true is the only way to stay, so unknown inputs force a reload.
      DONE: if ((vec_a == cap_a) && (vec_b == cap_b)) nxt = DONE;
            else nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_a     <= '0;
      cap_b     <= '0;
      mask      <= '0;
      acc       <= '0;
      out_Final <= '0;
    end else begin
      case (state)
        LOAD: begin
          cap_a <= vec_a;
          cap_b <= vec_b;
          acc   <= '0;
          mask  <= load_mask;
        end
        SCAN: begin
          if (pick_vld) begin
            acc            <= acc_sum;
            mask[pick_idx] <= 1'b0;
          end else begin
            out_Final <= acc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sparse.sv
// Scoreboard bench for sparse: each vector pair pushes its expected result and
// commit latency (edges from the trigger) and the checker pops and compares.
module tb_sparse;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] Vector_A = '0;
  logic [127:0] Vector_B = '0;
  logic [24:0]  out_Final;

  typedef struct {
    logic [24:0] val;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [24:0] prev = '0;
  logic [127:0] last_a = '0, last_b = '0;

  sparse dut (
    .clk       (clk),
    .rst       (rst),
    .Vector_A  (Vector_A),
    .Vector_B  (Vector_B),
    .out_Final (out_Final)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] dot(input logic [127:0] a, input logic [127:0] b);
    logic [24:0] s = '0;
    for (int i = 0; i < 16; i++) s += 25'(a[8*i +: 8]) * 25'(b[8*i +: 8]);
    return s;
  endfunction

  function automatic int kcount(input logic [127:0] a, input logic [127:0] b);
    int k = 0;
`ifdef SPARSE_SKIP_EN
    for (int i = 0; i < 16; i++) if (a[8*i +: 8] != 0 && b[8*i +: 8] != 0) k++;
`else
    k = 16;
`endif
    return k;
  endfunction

  // Trigger edge (DONE->LOAD or IDLE->LOAD) is 1, LOAD edge 2, commit at K+3.
  task automatic push(input logic [127:0] a, input logic [127:0] b);
    exp_t e;
    e.val = dot(a, b);
    e.lat = kcount(a, b) + 3;
    sb.push_back(e);
    last_a = a;
    last_b = b;
  endtask

  task automatic drive(input logic [127:0] a, input logic [127:0] b);
    @(negedge clk);
    Vector_A = a;
    Vector_B = b;
    push(a, b);
  endtask

  task automatic check_item(input string name, input int elapsed);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    for (int c = elapsed + 1; c <= e.lat; c++) begin
      @(posedge clk); #1;
      if (c == e.lat - 1) begin
        checks++;
        if (out_Final !== prev) begin
          failures++;
          $display("FAIL %s_hold: got %0d expected %0d", name, out_Final, prev);
        end
      end
    end
    checks++;
    if (out_Final !== e.val) begin
      failures++;
      $display("FAIL %s_result: got %0d expected %0d", name, out_Final, e.val);
    end
    prev = e.val;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_Final !== 25'd0) begin
      failures++;
      $display("FAIL reset: got %0d expected 0", out_Final);
    end
    @(negedge clk);
    Vector_A = '1;
    Vector_B = '1;
    push('1, '1);
    rst = 1'b1;
    check_item("all_ff_after_reset", 0);
  endtask

  task automatic test_done_hold();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_Final !== prev) begin
      failures++;
      $display("FAIL done_hold: got %0d expected %0d", out_Final, prev);
    end
  endtask

  task automatic test_patterns();
    logic [127:0] ramp;
    for (int i = 0; i < 16; i++) ramp[8*i +: 8] = 8'(i);
    drive('0, '1);
    check_item("zero_a", 0);
    drive(128'h3, 128'h5);
    check_item("single", 0);
    drive('1, '1);
    check_item("change_in_done", 0);
    drive({16{8'h01}}, ramp);
    check_item("ramp", 0);
  endtask

  task automatic test_ignore_mid_scan();
    logic [127:0] ramp;
    for (int i = 0; i < 16; i++) ramp[8*i +: 8] = 8'(i);
    drive('1, '1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    Vector_A = {16{8'h01}};
    Vector_B = ramp;
    check_item("ignore_mid_scan", 5);
    push({16{8'h01}}, ramp);
    check_item("restart_after_done", 0);
  endtask

  task automatic test_reset_mid_scan();
    drive('1, '1);
    void'(sb.pop_back());
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_Final !== 25'd0) begin
      failures++;
      $display("FAIL reset_mid_scan: got %0d expected 0", out_Final);
    end
    prev = '0;
    @(negedge clk);
    rst = 1'b1;
    push('1, '1);
    check_item("recompute_after_reset", 0);
  endtask

  task automatic test_random();
    logic [127:0] a, b;
    for (int n = 0; n < 6; n++) begin
      do begin
        for (int i = 0; i < 16; i++) begin
          a[8*i +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
          b[8*i +: 8] = ($urandom_range(0, 2) != 0) ? 8'($urandom) : 8'h00;
        end
      end while (a == last_a && b == last_b);
      drive(a, b);
      check_item("random", 0);
    end
  endtask

  initial begin
    test_reset();
    test_done_hold();
    test_patterns();
    test_ignore_mid_scan();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
